// File: rtl/tetris_pkg.sv
// Shared definitions for the falling-piece logic: board geometry, move
// directions (doubling as checker enable indices) and the move FSM states.
package tetris_pkg;

  localparam int BOARD_ROWS = 20;
  localparam int BOARD_COLS = 16;
  localparam int PIECE_SPAN = 4;

  // The piece origin is its top-left corner, so a 4x4 piece stops four
  // cells short of the far edges.
  localparam int DEF_MAX_X = BOARD_COLS - PIECE_SPAN;
  localparam int DEF_MAX_Y = BOARD_ROWS - PIECE_SPAN;

  typedef enum logic [1:0] {
    DIR_LEFT  = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_NONE  = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    EVAL  = 2'd2
  } state_e;

  function automatic logic [2:0] dir_onehot(input dir_e d);
    logic [2:0] oh;
    oh = 3'b000;
    case (d)
      DIR_LEFT:  oh = 3'b001;
      DIR_RIGHT: oh = 3'b010;
      DIR_DOWN:  oh = 3'b100;
      default:   oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/drop_timer.sv
// Gravity timer: emits a one-cycle tick every DROP_PERIOD enabled cycles.
module drop_timer #(
  parameter int DROP_PERIOD = 25000000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DROP_PERIOD > 1) ? $clog2(DROP_PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(DROP_PERIOD - 1);

  logic [CW-1:0] cnt;

  assign tick = run && (cnt == LAST);

  // clear wins over counting so a manual down or spawn restarts the period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/piece_move_controller.sv
// Requester side of the move-check handshake: arbitrates move requests,
// enables one collision checker, and commits or rejects the piece position.
module piece_move_controller
  import tetris_pkg::*;
#(
  parameter int SPAWN_X     = 6,
  parameter int MAX_X       = DEF_MAX_X,
  parameter int MAX_Y       = DEF_MAX_Y,
  parameter int DROP_PERIOD = 25000000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       run,
  input  logic       spawn,
  input  logic       moveLeft,
  input  logic       moveRight,
  input  logic       moveDown,
  input  logic       canMoveLeft,
  input  logic       canMoveRight,
  input  logic       canMoveDown,
  output logic [2:0] checkEnable,
  output logic [3:0] XPOS,
  output logic [4:0] YPOS,
  output logic       busy,
  output logic       moveDone,
  output logic       landed
);

  localparam logic [3:0] SPAWN_X_L = 4'(SPAWN_X);
  localparam logic [3:0] MAX_X_L   = 4'(MAX_X);
  localparam logic [4:0] MAX_Y_L   = 5'(MAX_Y);

  state_e     state, state_nxt;
  dir_e       dir, dir_nxt;
  logic       pend_spawn;
  logic       take_spawn;
  logic       take_down_manual;
  logic       ok;
  logic       tick;
  logic [3:0] x;
  logic [4:0] y;

  drop_timer #(
    .DROP_PERIOD(DROP_PERIOD)
  ) u_drop_timer (
    .clk  (Clock),
    .rst  (Reset),
    .run  (run && (state == IDLE)),
    .clear(take_spawn || take_down_manual),
    .tick (tick)
  );

  always_comb begin
    state_nxt        = state;
    dir_nxt          = dir;
    take_spawn       = 1'b0;
    take_down_manual = 1'b0;
    ok               = 1'b0;
    case (state)
      IDLE: begin
        if (spawn || pend_spawn) begin
          take_spawn = 1'b1;
        end else if (moveDown || tick) begin
          dir_nxt          = DIR_DOWN;
          state_nxt        = ISSUE;
          take_down_manual = moveDown;
        end else if (moveLeft) begin
          dir_nxt   = DIR_LEFT;
          state_nxt = ISSUE;
        end else if (moveRight) begin
          dir_nxt   = DIR_RIGHT;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = EVAL;
      EVAL: begin
        state_nxt = IDLE;
        // position guards keep XPOS/YPOS from wrapping whatever the checker says
        case (dir)
          DIR_LEFT:  ok = canMoveLeft  && (x != 4'd0);
          DIR_RIGHT: ok = canMoveRight && (x < MAX_X_L);
          DIR_DOWN:  ok = canMoveDown  && (y < MAX_Y_L);
          default:   ok = 1'b0;
        endcase
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      dir        <= DIR_NONE;
      pend_spawn <= 1'b0;
      x          <= SPAWN_X_L;
      y          <= '0;
      moveDone   <= 1'b0;
      landed     <= 1'b0;
    end else begin
      state    <= state_nxt;
      dir      <= dir_nxt;
      moveDone <= 1'b0;
      landed   <= 1'b0;
      // a spawn arriving mid-check must not be lost; replay it once idle
      if ((state != IDLE) && spawn) begin
        pend_spawn <= 1'b1;
      end else if (take_spawn) begin
        pend_spawn <= 1'b0;
      end
      if (take_spawn) begin
        x <= SPAWN_X_L;
        y <= '0;
      end else if (state == EVAL) begin
        if (ok) begin
          moveDone <= 1'b1;
          case (dir)
            DIR_LEFT:  x <= x - 4'd1;
            DIR_RIGHT: x <= x + 4'd1;
            DIR_DOWN:  y <= y + 5'd1;
            default:   ;
          endcase
        end else if (dir == DIR_DOWN) begin
          landed <= 1'b1;
        end
      end
    end
  end

  assign checkEnable = (state == ISSUE) ? dir_onehot(dir) : 3'b000;
  assign busy        = (state != IDLE);
  assign XPOS        = x;
  assign YPOS        = y;

endmodule

// File: tb/tb_piece_move_controller.sv
// Scoreboard bench for piece_move_controller: expected outcomes are queued
// as requests are driven and compared when each check completes.
module tb_piece_move_controller;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       run = 1'b0, spawn = 1'b0;
  logic       moveLeft = 1'b0, moveRight = 1'b0, moveDown = 1'b0;
  logic       canMoveLeft = 1'b0, canMoveRight = 1'b0, canMoveDown = 1'b0;
  logic [2:0] checkEnable;
  logic [3:0] XPOS;
  logic [4:0] YPOS;
  logic       busy, moveDone, landed;

  always #5 Clock = ~Clock;

  piece_move_controller #(
    .SPAWN_X(6), .MAX_X(12), .MAX_Y(16), .DROP_PERIOD(4)
  ) dut (
    .Clock(Clock), .Reset(Reset), .run(run), .spawn(spawn),
    .moveLeft(moveLeft), .moveRight(moveRight), .moveDown(moveDown),
    .canMoveLeft(canMoveLeft), .canMoveRight(canMoveRight), .canMoveDown(canMoveDown),
    .checkEnable(checkEnable), .XPOS(XPOS), .YPOS(YPOS),
    .busy(busy), .moveDone(moveDone), .landed(landed)
  );

  typedef struct {
    logic [2:0] en;
    logic [3:0] x;
    logic [4:0] y;
    logic       done;
    logic       land;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   en_times[$];
  int   n_tests = 0, n_fail = 0;
  int   cyc = 0;
  int   phase = 0;
  int   mx = 6, my = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  always @(posedge Clock) cyc++;

  // Monitor: pop an expectation when a checker enable appears, then score
  // the one-cycle enable and the result two cycles later.
  always @(negedge Clock) begin
    if (Reset) begin
      phase = 0;
    end else begin
      case (phase)
        0: begin
          if (checkEnable != 3'b000) begin
            en_times.push_back(cyc);
            if (exp_q.size() == 0) begin
              check("unexpected_enable", 32'(checkEnable), 32'd0);
            end else begin
              cur = exp_q.pop_front();
              check("enable", 32'(checkEnable), 32'(cur.en));
              check("busy_issue", 32'(busy), 32'd1);
            end
            phase = 1;
          end else begin
            check("idle_move_done", 32'(moveDone), 32'd0);
            check("idle_landed", 32'(landed), 32'd0);
          end
        end
        1: begin
          check("enable_one_cycle", 32'(checkEnable), 32'd0);
          check("busy_eval", 32'(busy), 32'd1);
          phase = 2;
        end
        default: begin
          check("xpos", 32'(XPOS), 32'(cur.x));
          check("ypos", 32'(YPOS), 32'(cur.y));
          check("move_done", 32'(moveDone), 32'(cur.done));
          check("landed", 32'(landed), 32'(cur.land));
          check("busy_after", 32'(busy), 32'd0);
          phase = 0;
        end
      endcase
    end
  end

  // Entered and left #1 after a posedge with the DUT idle.
  task automatic do_move(input logic l, r, d, cl, cr, cd);
    exp_t e;
    logic ok;
    canMoveLeft  = cl;
    canMoveRight = cr;
    canMoveDown  = cd;
    if (l || r || d) begin
      e.land = 1'b0;
      if (d) begin
        e.en = 3'b100;
        ok = cd && (my < 16);
        if (ok) my++;
        e.land = !ok;
      end else if (l) begin
        e.en = 3'b001;
        ok = cl && (mx > 0);
        if (ok) mx--;
      end else begin
        e.en = 3'b010;
        ok = cr && (mx < 12);
        if (ok) mx++;
      end
      e.done = ok;
      e.x = 4'(mx);
      e.y = 5'(my);
      exp_q.push_back(e);
    end
    moveLeft  = l;
    moveRight = r;
    moveDown  = d;
    @(posedge Clock); #1;
    moveLeft  = 1'b0;
    moveRight = 1'b0;
    moveDown  = 1'b0;
    @(posedge Clock);
    @(posedge Clock); #1;
  endtask

  task automatic do_spawn(input logic with_left);
    spawn    = 1'b1;
    moveLeft = with_left;
    @(posedge Clock); #1;
    spawn    = 1'b0;
    moveLeft = 1'b0;
    mx = 6;
    my = 0;
    check("spawn_x", 32'(XPOS), 32'd6);
    check("spawn_y", 32'(YPOS), 32'd0);
    check("spawn_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   c0;
    Reset = 1'b1;
    #2;
    check("rst_x", 32'(XPOS), 32'd6);
    check("rst_y", 32'(YPOS), 32'd0);
    check("rst_en", 32'(checkEnable), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(moveDone), 32'd0);
    check("rst_landed", 32'(landed), 32'd0);
    @(posedge Clock);
    @(posedge Clock); #1;
    Reset = 1'b0;

    // left moves 6 -> 3
    for (int i = 0; i < 3; i++) do_move(1, 0, 0, 1, 0, 0);

    // reset asynchronously in the middle of EVAL at XPOS=3
    e.en = 3'b001; e.x = 4'd2; e.y = 5'd0; e.done = 1'b1; e.land = 1'b0;
    exp_q.push_back(e);
    moveLeft = 1'b1;
    @(posedge Clock); #1;
    moveLeft = 1'b0;
    @(posedge Clock); #2;
    check("pre_rst_x", 32'(XPOS), 32'd3);
    Reset = 1'b1;
    #1;
    check("mid_rst_x", 32'(XPOS), 32'd6);
    check("mid_rst_y", 32'(YPOS), 32'd0);
    check("mid_rst_en", 32'(checkEnable), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(moveDone), 32'd0);
    check("mid_rst_landed", 32'(landed), 32'd0);
    exp_q.delete();
    mx = 6; my = 0;
    @(posedge Clock);
    @(posedge Clock); #1;
    Reset = 1'b0;
    @(posedge Clock); #1;
    check("post_rst_x", 32'(XPOS), 32'd6);

    // simultaneous requests: down wins
    do_move(1, 1, 1, 1, 1, 1);
    // right up to the edge, then rejected at MAX_X
    for (int i = 0; i < 7; i++) do_move(0, 1, 0, 0, 1, 0);
    // left refused by checker: silent
    do_move(1, 0, 0, 0, 0, 0);
    // down to the floor, then guard rejects and piece lands
    for (int i = 0; i < 16; i++) do_move(0, 0, 1, 0, 0, 1);

    // spawn beats a same-cycle move request
    do_spawn(1'b1);
    @(posedge Clock); #1;
    // left down to column 0, then guard rejects
    for (int i = 0; i < 7; i++) do_move(1, 0, 0, 1, 0, 0);
    // checker refuses down: landing without movement
    do_move(0, 0, 1, 0, 0, 0);

    // gravity with DROP_PERIOD=4, spawn arriving during the third EVAL
    do_spawn(1'b0);
    canMoveDown = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      e.en = 3'b100; e.x = 4'd6; e.y = 5'(i); e.done = 1'b1; e.land = 1'b0;
      exp_q.push_back(e);
    end
    en_times.delete();
    run = 1'b1;
    c0 = cyc;
    repeat (17) @(posedge Clock);
    #1;
    spawn = 1'b1;
    run   = 1'b0;
    @(posedge Clock); #1;
    spawn = 1'b0;
    check("pending_spawn_busy", 32'(busy), 32'd0);
    @(posedge Clock); #1;
    check("pending_spawn_x", 32'(XPOS), 32'd6);
    check("pending_spawn_y", 32'(YPOS), 32'd0);
    check("gravity_count", 32'(en_times.size()), 32'd3);
    if (en_times.size() == 3) begin
      check("gravity_first", 32'(en_times[0] - c0), 32'd4);
      check("gravity_period1", 32'(en_times[1] - en_times[0]), 32'd6);
      check("gravity_period2", 32'(en_times[2] - en_times[1]), 32'd6);
    end

    repeat (5) @(posedge Clock);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/piece_move_controller.md
Name: piece_move_controller

Overview:
- Requester side of the move-check interface.
- Takes player move requests (left/right/down) plus an internal gravity timer, and drives the one-hot Enable of the left/right/down collision checkers.
- Samples each checker's registered canMove one cycle later and commits the new XPOS/YPOS, or reports a landing.
- Sits between input debounce/edge-detect and the board/checker logic; it is the sole owner of the falling piece position.

Parameters:
- SPAWN_X, 6, XPOS loaded on reset and on spawn
- MAX_X, 12, largest legal XPOS; right move rejected at XPOS >= MAX_X
- MAX_Y, 16, largest legal YPOS; down move rejected at YPOS >= MAX_Y
- DROP_PERIOD, 25000000, Clock cycles between gravity down requests (counter width $clog2(DROP_PERIOD))

Ports:
- Clock  in  1  system clock, all state on posedge
- Reset  in  1  asynchronous, active-high; clears all state immediately
- run  in  1  gravity timer enable (game active)
- spawn  in  1  pulse: new piece; reload position
- moveLeft  in  1  pulse: request one column left
- moveRight  in  1  pulse: request one column right
- moveDown  in  1  pulse: request one row down
- canMoveLeft  in  1  registered result from left checker
- canMoveRight  in  1  registered result from right checker
- canMoveDown  in  1  registered result from down checker
- checkEnable  out  3  one-hot Enable to checkers: [0] left, [1] right, [2] down
- XPOS  out  4  piece column
- YPOS  out  5  piece row
- busy  out  1  high while a check is in flight
- moveDone  out  1  one-cycle pulse: move committed
- landed  out  1  one-cycle pulse: down move rejected, piece has landed

Behaviour:
- Reset values: XPOS=SPAWN_X, YPOS=0, checkEnable=0, busy=0, moveDone=0, landed=0, state IDLE, drop timer=0, pending direction=none.
- Reset asserted mid-check aborts the check; no commit.
- FSM states: IDLE, ISSUE, EVAL.
- IDLE:
  - Highest-priority active request wins: spawn > moveDown/gravity > moveLeft > moveRight.
  - spawn handling: XPOS<=SPAWN_X, YPOS<=0, drop timer<=0; stay IDLE; no moveDone.
  - Any move request: latch direction, go to ISSUE.
  - Requests losing priority are dropped, not queued.
- ISSUE (1 cycle):
  - checkEnable = one-hot of latched direction; busy=1.
  - XPOS/YPOS held stable, since checkers read them combinationally.
  - Always go to EVAL.
- EVAL (1 cycle):
  - checkEnable=0, busy=1.
  - ok = canMove[dir] AND guard, where guard is: left XPOS>0; right XPOS<MAX_X; down YPOS<MAX_Y.
  - ok=1: left XPOS-1, right XPOS+1, down YPOS+1; moveDone pulses for the cycle after EVAL.
  - ok=0 on down: landed pulses for the cycle after EVAL; position unchanged.
  - ok=0 on left/right: silent, no pulse.
  - Always return to IDLE.
- Latency: request in IDLE cycle N -> checkEnable high cycle N+1 -> position updated and pulse visible cycle N+3.
  - Back-to-back requests are accepted every 3 cycles minimum.
- busy: high in ISSUE and EVAL.
  - Move/spawn inputs are ignored while busy.
  - Exception: spawn during ISSUE/EVAL is latched as a pending spawn and serviced on the first IDLE cycle, with priority over new requests.
- Gravity timer:
  - Counts only while run=1 and state is IDLE.
  - On reaching DROP_PERIOD-1 it raises an internal down request and wraps to 0.
  - An accepted manual moveDown also clears it.
  - run=0 holds the count.
- No arithmetic wrap on XPOS/YPOS: the guards make XPOS=0 left and XPOS=MAX_X right impossible to commit even if the checker says 1.
- checkEnable is never multi-hot and never asserted outside ISSUE.

Decomposition:
- Shared package tetris_pkg holds:
  - direction encoding (DIR_LEFT=0, DIR_RIGHT=1, DIR_DOWN=2, used as checkEnable index)
  - FSM state enum
  - board dimensions (20 rows x 16 columns) from which MAX_X/MAX_Y defaults derive
- One natural sub-module: drop_timer (run, clear, tick out; parameter DROP_PERIOD).
- The FSM and position registers stay in the top.

Test Plan:
- Reset with XPOS=3 mid-EVAL:
  - XPOS=6, YPOS=0, all pulses 0 immediately, without waiting for a clock edge.
- moveLeft at XPOS=6, canMoveLeft=1 in EVAL:
  - checkEnable=3'b001 exactly one cycle, XPOS=5 and moveDone=1 three cycles after request.
- moveDown at YPOS=16, canMoveDown=1:
  - guard rejects; YPOS stays 16, landed=1 one cycle, moveDone=0.
- Same-cycle moveLeft+moveRight+moveDown:
  - only checkEnable=3'b100 issued; YPOS+1; left/right dropped.
- moveRight at XPOS=12 with canMoveRight=1:
  - XPOS stays 12, no pulses.
- DROP_PERIOD=4, run=1, no inputs:
  - checkEnable=3'b100 every 4 IDLE cycles plus 2 busy cycles; spawn during EVAL reloads XPOS=6, YPOS=0 on next IDLE cycle.
